// File: rtl/gpr_scoreboard_if.sv
// gpr_scoreboard_if
//   Bundles the read, write, issue and hazard signals of the GPR scoreboard.
//   Clock and reset stay outside the interface as plain ports of the block.
//
//   Signal semantics (all sampled on the rising clock edge, no handshake):
//     RegWrite/RD_WA/WData  main writeback; commits when RegWrite=1, RD_WA!=0
//     Ifjal/PC_4            link writeback into LINK_REG
//     Issue/IssueWA         an instruction that will write IssueWA has issued
//     RS1/RS2 -> RData1/RData2, Busy1/Busy2, Hazard   combinational reads
//
//   Modports:
//     master : the pipeline side (drives indices, writes, issues)
//     slave  : the register file / scoreboard
interface gpr_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] RS1;
  logic [ADDR_W-1:0] RS2;
  logic [DATA_W-1:0] RData1;
  logic [DATA_W-1:0] RData2;
  logic              RegWrite;
  logic [ADDR_W-1:0] RD_WA;
  logic [DATA_W-1:0] WData;
  logic              Ifjal;
  logic [DATA_W-1:0] PC_4;
  logic              Issue;
  logic [ADDR_W-1:0] IssueWA;
  logic              Busy1;
  logic              Busy2;
  logic              Hazard;

  modport master (
    output RS1, RS2, RegWrite, RD_WA, WData, Ifjal, PC_4, Issue, IssueWA,
    input  RData1, RData2, Busy1, Busy2, Hazard
  );

  modport slave (
    input  RS1, RS2, RegWrite, RD_WA, WData, Ifjal, PC_4, Issue, IssueWA,
    output RData1, RData2, Busy1, Busy2, Hazard
  );
endinterface

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard
//   General-purpose register file with a per-register busy scoreboard for
//   the pipelined datapath. Register 0 is hardwired to zero.
//
//   Ports:
//     Clk       clock, all state updates on the rising edge
//     ResetReg  synchronous active-low reset (clears registers and busy bits)
//     bus       gpr_scoreboard_if.slave: two async read ports, main write,
//               link write (LINK_REG), issue tracking, Busy1/Busy2/Hazard
//
//   Parameters: DATA_W (register width), ADDR_W (index width, depth
//   2**ADDR_W), LINK_REG (index written by the link port).
//
//   Optional build macro GPR_BYPASS_EN: forwards a committing write to the
//   read ports in the same cycle. Without it, reads return stored contents.
module gpr_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input logic             Clk,
  input logic             ResetReg,
  gpr_scoreboard_if.slave bus
);
  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
  localparam bit                LINK_EN  = (LINK_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic              main_we;
  logic              link_we;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              busy1;
  logic              busy2;

  // The link write wins a same-index collision, so the main write is
  // suppressed rather than relying on statement order.
  assign link_we = bus.Ifjal && LINK_EN;
  assign main_we = bus.RegWrite && (bus.RD_WA != '0) &&
                   !(link_we && (bus.RD_WA == LINK_IDX));

  // Clear on commit first, then set on issue: a newer instruction issuing
  // to the same register keeps it pending.
  always_comb begin
    busy_next = busy;
    if (main_we) busy_next[bus.RD_WA] = 1'b0;
    if (link_we) busy_next[LINK_IDX]  = 1'b0;
    if (bus.Issue && (bus.IssueWA != '0)) busy_next[bus.IssueWA] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (!ResetReg) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (main_we) regs[bus.RD_WA] <= bus.WData;
      if (link_we) regs[LINK_IDX]  <= bus.PC_4;
      busy <= busy_next;
    end
  end

  always_comb begin
    rdata1 = (bus.RS1 == '0) ? '0 : regs[bus.RS1];
    rdata2 = (bus.RS2 == '0) ? '0 : regs[bus.RS2];
    busy1  = busy[bus.RS1];
    busy2  = busy[bus.RS2];
`ifdef GPR_BYPASS_EN
    // main_we/link_we already exclude index 0, so a match implies RSN != 0.
    if (!ResetReg) begin
      rdata1 = '0;
      rdata2 = '0;
    end else begin
      if (main_we && (bus.RD_WA == bus.RS1)) begin
        rdata1 = bus.WData;
        busy1  = 1'b0;
      end
      if (link_we && (LINK_IDX == bus.RS1)) begin
        rdata1 = bus.PC_4;
        busy1  = 1'b0;
      end
      if (main_we && (bus.RD_WA == bus.RS2)) begin
        rdata2 = bus.WData;
        busy2  = 1'b0;
      end
      if (link_we && (LINK_IDX == bus.RS2)) begin
        rdata2 = bus.PC_4;
        busy2  = 1'b0;
      end
    end
`endif
  end

  assign bus.RData1 = rdata1;
  assign bus.RData2 = rdata2;
  assign bus.Busy1  = busy1;
  assign bus.Busy2  = busy2;
  assign bus.Hazard = busy1 | busy2;
endmodule

// File: tb/tb_gpr_scoreboard.sv
module tb_gpr_scoreboard;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int LINK   = 31;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic ResetReg = 1'b1;
  always #5 Clk = ~Clk;

  gpr_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  gpr_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINK_REG(LINK)) dut (
    .Clk      (Clk),
    .ResetReg (ResetReg),
    .bus      (bus)
  );

  // ---------------- reference model + scoreboard ----------------
  logic [DATA_W-1:0] m_regs [DEPTH];
  logic              m_busy [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  logic [2:0]        exp_flag_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                          input logic [DATA_W-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Applies the rules to the inputs that were present at the edge.
  task automatic model_edge();
    if (!ResetReg) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (bus.RegWrite && bus.RD_WA != 0 && !(bus.Ifjal && bus.RD_WA == LINK)) begin
        m_regs[bus.RD_WA] = bus.WData;
        m_busy[bus.RD_WA] = 1'b0;
      end
      if (bus.Ifjal) begin
        m_regs[LINK] = bus.PC_4;
        m_busy[LINK] = 1'b0;
      end
      if (bus.Issue && bus.IssueWA != 0) m_busy[bus.IssueWA] = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.RegWrite = 1'b0; bus.RD_WA = '0; bus.WData = '0;
    bus.Ifjal = 1'b0; bus.PC_4 = '0;
    bus.Issue = 1'b0; bus.IssueWA = '0;
    ResetReg = 1'b1;
  endtask

  task automatic set_inputs(input logic rst_n, input logic we, input int wa,
                            input logic [DATA_W-1:0] wd, input logic jal,
                            input logic [DATA_W-1:0] pc, input logic iss,
                            input int iwa);
    ResetReg = rst_n;
    bus.RegWrite = we; bus.RD_WA = ADDR_W'(wa); bus.WData = wd;
    bus.Ifjal = jal; bus.PC_4 = pc;
    bus.Issue = iss; bus.IssueWA = ADDR_W'(iwa);
  endtask

  // One clock edge with the currently applied inputs, then back to idle.
  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    idle_inputs();
  endtask

  task automatic cycle(input logic rst_n, input logic we, input int wa,
                       input logic [DATA_W-1:0] wd, input logic jal,
                       input logic [DATA_W-1:0] pc, input logic iss,
                       input int iwa);
    set_inputs(rst_n, we, wa, wd, jal, pc, iss, iwa);
    step();
  endtask

  // Pushes expected read results, samples at the falling edge, compares.
  task automatic read_check(input string tag, input int rs1, input int rs2);
    logic [DATA_W-1:0] e;
    logic [2:0]        f;
    logic              b1, b2;
    bus.RS1 = ADDR_W'(rs1);
    bus.RS2 = ADDR_W'(rs2);
    b1 = (rs1 == 0) ? 1'b0 : m_busy[rs1];
    b2 = (rs2 == 0) ? 1'b0 : m_busy[rs2];
    exp_q.push_back((rs1 == 0) ? '0 : m_regs[rs1]);
    exp_q.push_back((rs2 == 0) ? '0 : m_regs[rs2]);
    exp_flag_q.push_back({b1 | b2, b2, b1});
    @(negedge Clk);
    e = exp_q.pop_front();
    check_eq($sformatf("%s rdata1[%0d]", tag, rs1), bus.RData1, e);
    e = exp_q.pop_front();
    check_eq($sformatf("%s rdata2[%0d]", tag, rs2), bus.RData2, e);
    f = exp_flag_q.pop_front();
    check_eq($sformatf("%s busy1[%0d]", tag, rs1), 32'(bus.Busy1), 32'(f[0]));
    check_eq($sformatf("%s busy2[%0d]", tag, rs2), 32'(bus.Busy2), 32'(f[1]));
    check_eq($sformatf("%s hazard", tag), 32'(bus.Hazard), 32'(f[2]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    idle_inputs();
    bus.RS1 = '0; bus.RS2 = '0;
    @(negedge Clk);

    // Reset overrides a concurrent write and issue.
    cycle(1'b0, 1'b1, 5, 32'hDEAD_BEEF, 1'b0, '0, 1'b1, 5);
    for (int i = 0; i < DEPTH; i += 2) read_check("reset", i, i + 1);
    read_check("reset_r5", 5, 5);

    // Basic write/read, with same-cycle view when forwarding is built in.
    set_inputs(1'b1, 1'b1, 3, 32'h1234_5678, 1'b0, '0, 1'b0, 0);
`ifdef GPR_BYPASS_EN
    bus.RS1 = 5'd3;
    @(negedge Clk);
    check_eq("bypass rdata1[3]", bus.RData1, 32'h1234_5678);
`endif
    step();
    read_check("write3", 3, 0);
    cycle(1'b1, 1'b1, 0, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, 0);
    read_check("write0", 3, 0);

    // Dual write to distinct indices, then same index (link wins).
    cycle(1'b1, 1'b1, 7, 32'hA, 1'b1, 32'h0040_0004, 1'b0, 0);
    read_check("dual", 7, 31);
    cycle(1'b1, 1'b1, 31, 32'h0BAD_0BAD, 1'b1, 32'h0040_0004, 1'b0, 0);
    read_check("dual_same", 31, 7);

    // Scoreboard set, clear, and issue to r0.
    cycle(1'b1, 1'b0, 0, '0, 1'b0, '0, 1'b1, 9);
    read_check("busy9", 9, 0);
    cycle(1'b1, 1'b1, 9, 32'h9999_0009, 1'b0, '0, 1'b0, 0);
    read_check("clear9", 9, 0);
    cycle(1'b1, 1'b0, 0, '0, 1'b0, '0, 1'b1, 0);
    read_check("issue0", 0, 9);

    // Set and clear on the same edge: set wins, data still written.
    cycle(1'b1, 1'b0, 0, '0, 1'b0, '0, 1'b1, 4);
    read_check("busy4", 0, 4);
    cycle(1'b1, 1'b1, 4, 32'h4444_0004, 1'b0, '0, 1'b1, 4);
    read_check("collide4", 4, 3);

    // Write to a non-busy register is legal.
    cycle(1'b1, 1'b1, 12, 32'hC0FF_EE12, 1'b0, '0, 1'b0, 0);
    read_check("nonbusy12", 12, 12);

    // Mid-operation reset, then normal writes resume.
    cycle(1'b1, 1'b0, 0, '0, 1'b0, '0, 1'b1, 2);
    cycle(1'b1, 1'b1, 2, 32'h2222_2222, 1'b0, '0, 1'b1, 31);
    cycle(1'b1, 1'b0, 0, '0, 1'b0, '0, 1'b1, 2);
    read_check("pre_reset", 2, 31);
    cycle(1'b0, 1'b1, 6, 32'h6666_6666, 1'b1, 32'h1, 1'b1, 6);
    for (int i = 0; i < DEPTH; i += 2) read_check("midreset", i, i + 1);
    cycle(1'b1, 1'b1, 6, 32'h6060_6060, 1'b0, '0, 1'b0, 0);
    read_check("resume", 6, 2);

    // Randomised traffic against the model.
    for (int n = 0; n < 80; n++) begin
      cycle(($urandom_range(0, 19) != 0),
            1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom(),
            ($urandom_range(0, 3) == 0), $urandom(),
            1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1));
      read_check("rand", $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
    end

    if (exp_q.size() != 0 || exp_flag_q.size() != 0)
      check_eq("queue_drain", 32'(exp_q.size() + exp_flag_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/gpr_scoreboard.md
Name: gpr_scoreboard

Overview:
- Parametrised general-purpose register file for the pipelined datapath; successor to the single-cycle GPR.
- Two asynchronous read ports, one main write port and one link write port (jal/jalr return address), both usable in the same cycle.
- Per-register busy scoreboard: set when a writing instruction issues, cleared on writeback; drives hazard flags to the stall logic.
- Register 0 is hardwired zero.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- LINK_REG, 31, index written by the link port

Ports:
- Clk  in  1  clock; all state updates on rising edge
- ResetReg  in  1  synchronous reset, active-low; sampled on rising Clk
- RS1  in  ADDR_W  read index, port 1
- RS2  in  ADDR_W  read index, port 2
- RData1  out  DATA_W  data at RS1 (combinational)
- RData2  out  DATA_W  data at RS2 (combinational)
- RegWrite  in  1  main write enable
- RD_WA  in  ADDR_W  main write index
- WData  in  DATA_W  main write data
- Ifjal  in  1  link write enable
- PC_4  in  DATA_W  link write data
- Issue  in  1  instruction issuing that will write IssueWA
- IssueWA  in  ADDR_W  destination of issuing instruction
- Busy1  out  1  RS1 has a pending write
- Busy2  out  1  RS2 has a pending write
- Hazard  out  1  Busy1 | Busy2

Behaviour:
- Reset (ResetReg==0 at edge): all registers = 0, all busy bits = 0; overrides every write/issue that cycle. After reset: RData1 = RData2 = 0, Busy1 = Busy2 = Hazard = 0.
- Reads: RDataN = reg[RSN]; index 0 always reads 0.
- Main write: at edge, if RegWrite and RD_WA != 0: reg[RD_WA] <= WData.
- Link write: at edge, if Ifjal: reg[LINK_REG] <= PC_4 (skipped if LINK_REG == 0).
- Both writes in one cycle to different indices: both take effect.
- Both to the same index: link write wins; main write dropped.
- Writes to index 0 ignored; reg[0] never changes.
- Scoreboard, busy[i], evaluated per edge:
  - Set: Issue and IssueWA == i and i != 0.
  - Clear: a write (main or link) commits to i.
  - Set and clear on the same index in the same edge: set wins (newer instruction pending).
  - Neither: hold.
  - busy[0] is constant 0.
- Busy1 = busy[RS1], Busy2 = busy[RS2], combinational; reflect state after the last edge, not same-cycle Issue.
- Latency:
  - Write visible on reads the cycle after the edge, unless GPR_BYPASS_EN is defined.
  - Busy set/clear visible the cycle after the edge.
- A write to a non-busy register is legal: data updates, busy stays 0.
- No counters; all indices in range by construction (full 2**ADDR_W depth).

Optional Feature:
- Macro GPR_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read forwarding: if RSN matches a committing write this cycle (nonzero index), RDataN returns that write data (link data when both match), and BusyN reads 0 for that index.
  - Forwarding gated by ResetReg == 1; returns 0 during reset.
- Not defined: reads return stored contents only; a new value appears the cycle after the edge.

Test Plan:
- Reset: drive ResetReg=0 with RegWrite=1, RD_WA=5, WData=32'hDEAD_BEEF, Issue=1, IssueWA=5 -> next cycle reg[5]=0, Busy=0, RData=0 for all RS.
- Write/read: RegWrite=1, RD_WA=3, WData=32'h1234_5678 -> RS1=3 reads 32'h1234_5678 next cycle (same cycle too if GPR_BYPASS_EN); RD_WA=0, WData=32'hFFFF_FFFF -> RS2=0 reads 0.
- Dual write: same cycle RegWrite RD_WA=7, WData=32'hA, Ifjal, PC_4=32'h0040_0004 -> reg[7]=32'hA, reg[31]=32'h0040_0004; repeat with RD_WA=31 -> reg[31]=32'h0040_0004.
- Scoreboard: Issue IssueWA=9; next cycle RS1=9 -> Busy1=1, Hazard=1; write 9 -> following cycle Busy1=0; Issue IssueWA=0 -> Busy stays 0.
- Set/clear collision: busy[4]=1; same edge RegWrite RD_WA=4 and Issue IssueWA=4 -> busy[4] remains 1, reg[4] updated.
- Mid-operation reset: busy[2], busy[31] set, regs nonzero, ResetReg=0 for one cycle -> all busy 0, all regs 0; normal writes resume the cycle after ResetReg returns to 1.
